pop_scheduler: RTL

POP_SCHEDULER -- requirements
Module: pop_scheduler

---
 rtl/pop_scheduler_pkg.sv | 19 +
 rtl/pop_scheduler_rr_next_queue.sv | 49 ++++
 rtl/pop_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pop_scheduler_pkg.sv
// Shared round-robin definitions for the pop scheduler:
// FSM encoding, default weight and default parameters.
package pop_scheduler_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam int DEF_QUEUE_QUANTITY = 4;
  localparam int DEF_DATA_BITS      = 8;
  localparam int DEF_WEIGHT_BITS    = 3;
  localparam int DEF_WEIGHT         = 1;

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pop_scheduler_rr_next_queue.sv
// Round-robin search: first eligible queue from start_idx upward
// with wrap, skipping exclude_idx unless it is the only candidate.
module rr_next_queue
  import pop_scheduler_pkg::*;
#(
  parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY
) (
  input  logic [QUEUE_QUANTITY-1:0]           eligible,
  input  logic [sel_bits(QUEUE_QUANTITY)-1:0] start_idx,
  input  logic [sel_bits(QUEUE_QUANTITY)-1:0] exclude_idx,
  output logic [sel_bits(QUEUE_QUANTITY)-1:0] next_idx,
  output logic                                found
);

  localparam int SW = sel_bits(QUEUE_QUANTITY);

  logic [QUEUE_QUANTITY-1:0] cand;
  logic [SW-1:0]             idx;
  int                        t;

  // Candidate mask: drop the excluded queue if anyone else is eligible.
  always_comb begin
    cand = eligible;
    cand[exclude_idx] = 1'b0;
    if (cand == '0) begin
      cand = eligible;
    end
  end

  // Walk upward from start_idx with wrap; keep the first hit.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    t        = 0;
    idx      = '0;
    for (int k = 0; k < QUEUE_QUANTITY; k++) begin
      t = int'(start_idx) + k;
      if (t >= QUEUE_QUANTITY) begin
        t = t - QUEUE_QUANTITY;
      end
      idx = SW'(t);
      if (!found && cand[idx]) begin
        found    = 1'b1;
        next_idx = idx;
      end
    end
  end

endmodule

// File: rtl/pop_scheduler.sv
// Weighted round-robin pop scheduler over N FWFT queues with
// per-queue burst credit, backpressure and registered output.
module pop_scheduler
  import pop_scheduler_pkg::*;
#(
  parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int WEIGHT_BITS    = DEF_WEIGHT_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY-1:0]           almost_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in,
  input  logic                                out_almost_full,
  input  logic                                cfg_wr,
  input  logic [sel_bits(QUEUE_QUANTITY)-1:0] cfg_sel,
  input  logic [WEIGHT_BITS-1:0]              cfg_weight,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic [sel_bits(QUEUE_QUANTITY)-1:0] selector,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                valid_out,
  output logic                                idle
);

  localparam int SW = sel_bits(QUEUE_QUANTITY);
  localparam logic [WEIGHT_BITS-1:0] W_DEF = WEIGHT_BITS'(DEF_WEIGHT);
  localparam logic [WEIGHT_BITS-1:0] W_ONE = WEIGHT_BITS'(1);
  localparam logic [SW-1:0] SEL_LAST = SW'(QUEUE_QUANTITY - 1);

  state_e                state_q, state_d;
  logic [SW-1:0]         selector_q, selector_d;
  logic [WEIGHT_BITS-1:0] credit_q, credit_d;
  logic [DATA_BITS-1:0]  data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;

  logic [WEIGHT_BITS-1:0] weight_q [QUEUE_QUANTITY];
  logic [WEIGHT_BITS-1:0] weight_d [QUEUE_QUANTITY];

  logic [DATA_BITS-1:0]      head_arr [QUEUE_QUANTITY];
  logic [DATA_BITS-1:0]      head_data;
  logic [QUEUE_QUANTITY-1:0] eligible;
  logic [SW-1:0]             start_idx;
  logic [SW-1:0]             next_idx;
  logic                      found;
  logic                      advance;
  logic                      head_empty;
  logic                      pop_now;
  logic                      burst_end;

  // Unpack queue heads and derive per-queue eligibility.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      head_arr[i] = data_in[i*DATA_BITS +: DATA_BITS];
      eligible[i] = ~buf_empty[i] & (weight_q[i] != '0);
    end
  end

  assign head_data  = head_arr[selector_q];
  assign head_empty = buf_empty[selector_q];
  assign advance    = enb & ~out_almost_full;
  assign pop_now    = (state_q == SERVE) & advance & ~head_empty;
  assign start_idx  = (selector_q == SEL_LAST) ? '0
                                               : selector_q + SW'(1);

  rr_next_queue #(
    .QUEUE_QUANTITY(QUEUE_QUANTITY)
  ) u_rr_next_queue (
    .eligible   (eligible),
    .start_idx  (start_idx),
    .exclude_idx(selector_q),
    .next_idx   (next_idx),
    .found      (found)
  );

  // One-hot dequeue strobe for the served queue.
  always_comb begin
    pop = '0;
    if (pop_now) begin
      pop[selector_q] = 1'b1;
    end
  end

  // Weight file update; frozen while disabled.
  always_comb begin
    weight_d = weight_q;
    if (enb && cfg_wr) begin
      weight_d[cfg_sel] = cfg_weight;
    end
  end

  // Scheduler next state: burst start, credit spend, queue switch.
  always_comb begin
    state_d     = state_q;
    selector_d  = selector_q;
    credit_d    = credit_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    burst_end   = 1'b0;
    if (advance) begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_d    = SERVE;
            selector_d = next_idx;
            credit_d   = weight_q[next_idx];
          end
        end
        SERVE: begin
          if (head_empty) begin
            burst_end = 1'b1;
          end else begin
            valid_out_d = 1'b1;
            data_out_d  = head_data;
            credit_d    = credit_q - W_ONE;
            burst_end   = (credit_q == W_ONE) |
                          almost_empty[selector_q];
          end
          if (burst_end) begin
            if (found) begin
              selector_d = next_idx;
              credit_d   = weight_q[next_idx];
            end else begin
              state_d  = IDLE;
              credit_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      selector_q  <= '0;
      credit_q    <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      selector_q  <= selector_d;
      credit_q    <= credit_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Weight register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        weight_q[i] <= W_DEF;
      end
    end else begin
      weight_q <= weight_d;
    end
  end

  assign selector  = selector_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign idle      = (state_q == IDLE);

endmodule
